uart_rx_ctrl: RTL and testbench

Receive-side controller between the UART receiver and the byte consumer. It captures each completed byte into a small FIFO and presents bytes on a valid/ready stream. It also runs error recovery after framing errors and keeps sticky status and counters for the register interface.

---
 rtl/uart_rx_ctrl_pkg.sv | 16 +
 rtl/uart_rx_ctrl_if.sv | 22 ++
 rtl/uart_rx_ctrl_fifo.sv | 50 +++++
 rtl/uart_rx_ctrl.sv | 143 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and defaults for the UART receive-side controller.
// Imported as uart_pkg by the interface, FIFO and top.
package uart_pkg;

  typedef enum logic [1:0] {
    RUN,
    RECOVER,
    FLUSH
  } state_e;

  typedef logic [7:0] byte_t;

  localparam int QUIET_CYCLES   = 160;
  localparam int TIMEOUT_CYCLES = 640;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Byte stream from the receive FIFO head to the consumer.
// The producer drives data/valid; the consumer drives ready.
interface uart_rx_ctrl_if;
  import uart_pkg::*;

  byte_t outData;
  logic  outValid;
  logic  outReady;

  modport master (
    output outData,
    output outValid,
    input  outReady
  );

  modport slave (
    input  outData,
    input  outValid,
    output outReady
  );

endinterface

// File: rtl/uart_rx_ctrl_fifo.sv
// Flop-array synchronous FIFO; pointers carry one extra wrap bit.
// clear empties it in one cycle and overrides push/pop.
module sync_fifo #(
  parameter int Depth = 8,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] level
);

  localparam int AW = $clog2(Depth);

  logic [AW:0]  wr_q, rd_q;
  logic [W-1:0] mem_q [Depth];
  logic         do_pop, do_push;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level = wr_q - rd_q;

  // a pop in the same cycle frees the slot a full push needs
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: byte capture FIFO, framing-error recovery, status.
// Define UART_RX_CTRL_TIMEOUT_EN to build the idle-timeout counter.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int Depth         = 8,
  parameter int QuietCycles   = QUIET_CYCLES,
  parameter int TimeoutCycles = TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   rxDone,
  input  logic                   rxErr,
  input  byte_t                  rxData,
  uart_rx_ctrl_if.master         out,
  input  logic                   flush,
  input  logic                   clrStatus,
  output logic [$clog2(Depth):0] level,
  output logic                   overrun,
  output logic                   frameErr,
  output byte_t                  errCount,
  output logic                   recovering,
  output logic                   timeout
);

  localparam int QW = $clog2(QuietCycles + 1);
  localparam logic [QW-1:0] QLOAD = QW'(QuietCycles - 1);

  state_e        state_q, state_d;
  logic [QW-1:0] quiet_q, quiet_d;
  logic          pend_q;
  logic          ovr_q, ovr_d;
  logic          fe_q, fe_d;
  byte_t         ec_q, ec_d;
  logic          full, empty, pop, wr_req, push, clear;

  assign pop    = out.outValid && out.outReady;
  assign clear  = (state_q == FLUSH);
  // flush and rxErr both outrank a capture landing in the same cycle
  assign wr_req = pend_q && enable && (state_q == RUN) &&
                  !flush && !rxErr;
  assign push   = wr_req && (!full || pop);

  sync_fifo #(.Depth(Depth), .W(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (rxData),
    .dout  (out.outData),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign out.outValid = !empty;

  always_comb begin
    state_d = state_q;
    quiet_d = quiet_q;
    if (flush) begin
      state_d = FLUSH;
    end else if (rxErr) begin
      state_d = RECOVER;
      quiet_d = QLOAD;
    end else begin
      unique case (state_q)
        RUN:   state_d = RUN;
        RECOVER: begin
          if (rxDone)              quiet_d = QLOAD;
          else if (quiet_q == '0)  state_d = RUN;
          else                     quiet_d = quiet_q - 1'b1;
        end
        FLUSH:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    ovr_d = ovr_q;
    fe_d  = fe_q;
    ec_d  = ec_q;
    if (wr_req && full && !pop) ovr_d = 1'b1;
    else if (clrStatus)         ovr_d = 1'b0;
    if (rxErr)          fe_d = 1'b1;
    else if (clrStatus) fe_d = 1'b0;
    if (rxErr) begin
      if (clrStatus)           ec_d = 8'd1;
      else if (ec_q != 8'hFF)  ec_d = ec_q + 8'd1;
    end else if (clrStatus) begin
      ec_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      quiet_q <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
      ec_q    <= '0;
    end else begin
      state_q <= state_d;
      quiet_q <= quiet_d;
      pend_q  <= rxDone;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
      ec_q    <= ec_d;
    end
  end

  assign overrun    = ovr_q;
  assign frameErr   = fe_q;
  assign errCount   = ec_q;
  assign recovering = (state_q == RECOVER);

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam logic [TW-1:0] TMAX = TW'(TimeoutCycles);

  logic [TW-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q;
    if (push || pop || clear)         idle_d = '0;
    else if (!empty && idle_q != TMAX) idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end

  assign timeout = (idle_q == TMAX);
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed vector bench for uart_rx_ctrl.
// Table rows cover capture/pop/enable/flush; sequences cover the rest.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset, enable, rxDone, rxErr, flush, clrStatus;
  byte_t      rxData;
  logic [3:0] level;
  logic       overrun, frameErr, recovering, timeout;
  byte_t      errCount;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .rxDone     (rxDone),
    .rxErr      (rxErr),
    .rxData     (rxData),
    .out        (bus.master),
    .flush      (flush),
    .clrStatus  (clrStatus),
    .level      (level),
    .overrun    (overrun),
    .frameErr   (frameErr),
    .errCount   (errCount),
    .recovering (recovering),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, done, err;
    logic [7:0] data;
    logic       rdy, fl, clr;
    logic       v;
    logic [7:0] d;
    logic [3:0] lvl;
    logic       ovr;
  } vec_t;

  vec_t tbl [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_byte(byte_t b);
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    rxData = b;
    tick();
    rxData = '0;
  endtask

  task automatic pop_one();
    bus.outReady = 1'b1;
    tick();
    bus.outReady = 1'b0;
  endtask

  initial begin
    //            en done err data  rdy fl clr  v  d      lvl  ovr
    tbl[0]  = '{1, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 4'd0, 0};
    tbl[1]  = '{1, 0, 0, 8'hA5, 0, 0, 0, 1, 8'hA5, 4'd1, 0};
    tbl[2]  = '{1, 0, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 4'd1, 0};
    tbl[3]  = '{1, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 4'd0, 0};
    tbl[4]  = '{1, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 4'd0, 0};
    tbl[5]  = '{1, 0, 0, 8'h3C, 0, 0, 0, 1, 8'h3C, 4'd1, 0};
    tbl[6]  = '{0, 1, 0, 8'h00, 0, 0, 0, 1, 8'h3C, 4'd1, 0};
    tbl[7]  = '{0, 0, 0, 8'h77, 0, 0, 0, 1, 8'h3C, 4'd1, 0};
    tbl[8]  = '{1, 0, 0, 8'h00, 0, 1, 0, 1, 8'h3C, 4'd1, 0};
    tbl[9]  = '{1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 4'd0, 0};
    tbl[10] = '{1, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 4'd0, 0};
    tbl[11] = '{1, 0, 0, 8'h99, 0, 0, 0, 1, 8'h99, 4'd1, 0};
    tbl[12] = '{1, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 4'd0, 0};

    reset = 1'b1;
    enable = 1'b1;
    rxDone = 1'b0;
    rxErr = 1'b0;
    rxData = '0;
    flush = 1'b0;
    clrStatus = 1'b0;
    bus.outReady = 1'b0;
    tick();
    tick();
    chk("reset", {bus.outValid, bus.outData, level, overrun,
                  frameErr, errCount, recovering, timeout}, '0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      enable       = tbl[i].en;
      rxDone       = tbl[i].done;
      rxErr        = tbl[i].err;
      rxData       = tbl[i].data;
      bus.outReady = tbl[i].rdy;
      flush        = tbl[i].fl;
      clrStatus    = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d", i),
          {bus.outValid, bus.outData, level, overrun,
           frameErr, errCount, recovering},
          {tbl[i].v, tbl[i].d, tbl[i].lvl, tbl[i].ovr, 10'b0});
    end
    enable = 1'b1;
    rxDone = 1'b0;
    rxData = '0;
    bus.outReady = 1'b0;
    flush = 1'b0;

    for (int i = 1; i <= 9; i++) push_byte(byte_t'(i));
    chk("ovr_level", level, 8);
    chk("ovr_flag", overrun, 1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("ovr_rd%0d", i), bus.outData, i);
      pop_one();
    end
    chk("ovr_empty", {bus.outValid, level}, 0);
    chk("ovr_sticky", overrun, 1);
    clrStatus = 1'b1;
    tick();
    clrStatus = 1'b0;
    chk("ovr_clr", overrun, 0);

    for (int i = 0; i < 8; i++) push_byte(byte_t'(8'h10 + i));
    chk("pp_full", level, 8);
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    rxData = 8'h18;
    bus.outReady = 1'b1;
    tick();
    bus.outReady = 1'b0;
    rxData = '0;
    chk("pp_level", level, 8);
    chk("pp_ovr", overrun, 0);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("pp_rd%0d", i), bus.outData, 8'h10 + i);
      pop_one();
    end
    chk("pp_empty", level, 0);

    rxErr = 1'b1;
    tick();
    rxErr = 1'b0;
    chk("fe_state", {recovering, frameErr, errCount}, {1'b1, 1'b1, 8'd1});
    repeat (50) tick();
    push_byte(8'h55);
    repeat (158) tick();
    chk("fe_hold", recovering, 1);
    chk("fe_drop", {level, overrun}, 0);
    tick();
    chk("fe_exit", recovering, 0);
    push_byte(8'h66);
    chk("fe_next", {bus.outValid, bus.outData}, {1'b1, 8'h66});
    pop_one();

    rxErr = 1'b1;
    repeat (254) tick();
    chk("sat_255", errCount, 255);
    tick();
    chk("sat_hold", errCount, 255);
    clrStatus = 1'b1;
    tick();
    rxErr = 1'b0;
    clrStatus = 1'b0;
    chk("race", {frameErr, errCount}, {1'b1, 8'd1});
    clrStatus = 1'b1;
    tick();
    clrStatus = 1'b0;
    chk("clr_all", {overrun, frameErr, errCount}, 0);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_abandon", recovering, 0);
    tick();
    push_byte(8'h77);
    chk("fl_capture", {bus.outData, level}, {8'h77, 4'd1});

`ifdef UART_RX_CTRL_TIMEOUT_EN
    repeat (639) tick();
    chk("to_before", timeout, 0);
    tick();
    chk("to_assert", timeout, 1);
    pop_one();
    chk("to_clear", timeout, 0);
`else
    repeat (700) tick();
    chk("to_off", timeout, 0);
    pop_one();
`endif
    chk("final_empty", level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
